// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline control for an N-stage in-order core.
// Generates per-stage stall/flush/bubble, a register interlock against the
// destinations of in-flight instructions, and the fetch redirect handshake.
// Optional macro PIPE_FORWARD_EN: the interlock shrinks to load-use only and
// forwarding-source outputs o_fwd_rs1/o_fwd_rs2 are added.
module pipe_hazard_ctrl #(
   parameter int unsigned NUM_STAGES = 5,
   parameter int unsigned STG_W      = 3,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned ADDR_W     = 32
) (
   input  logic                  i_clk,
   input  logic                  i_reset,        // active-low, asynchronous
   input  logic [NUM_STAGES-1:0] i_stall_req,
   input  logic                  i_id_valid,
   input  logic [REG_ADDR_W-1:0] i_id_rs1,
   input  logic [REG_ADDR_W-1:0] i_id_rs2,
   input  logic                  i_id_rs1_used,
   input  logic                  i_id_rs2_used,
   input  logic [REG_ADDR_W-1:0] i_id_rd,
   input  logic                  i_id_rd_we,
   input  logic                  i_id_is_load,
   input  logic                  i_flush_req,
   input  logic [STG_W-1:0]      i_flush_src,
   input  logic [ADDR_W-1:0]     i_flush_addr,
   input  logic                  i_redirect_ack,
   output logic [NUM_STAGES-1:0] o_stall,
   output logic [NUM_STAGES-1:0] o_flush,
   output logic [NUM_STAGES-1:0] o_bubble,
   output logic                  o_hazard,
   output logic                  o_redirect_valid,
   output logic [ADDR_W-1:0]     o_redirect_addr
`ifdef PIPE_FORWARD_EN
   ,
   output logic [STG_W-1:0]      o_fwd_rs1,
   output logic [STG_W-1:0]      o_fwd_rs2
`endif
);

   // one tracked slot per stage 2..NUM_STAGES-1; slot k belongs to stage k+2
   localparam int unsigned T = NUM_STAGES - 2;

   logic [T-1:0]          r_slot_v;
   logic [T-1:0]          r_slot_we;
   logic [T-1:0]          r_slot_ld;
   logic [REG_ADDR_W-1:0] r_slot_rd [T];
   logic                  r_redirect_valid;
   logic [ADDR_W-1:0]     r_redirect_addr;

   logic [31:0]           w_src;
   logic                  w_flush_ok;
   logic [T-1:0]          w_live;
   logic                  w_raw;
   logic                  w_hazard;
   logic                  w_req_acc;
   logic [T-1:0]          w_in_v;
   logic [T-1:0]          w_in_we;
   logic [T-1:0]          w_in_ld;
   logic [REG_ADDR_W-1:0] w_in_rd [T];

   assign w_src      = 32'(i_flush_src);
   // flush from stage 0 or from beyond the last stage is ignored entirely
   assign w_flush_ok = i_flush_req && (w_src != 32'd0) && (w_src < NUM_STAGES);

   // a slot can conflict only if it holds a valid write to a non-x0 register
   always_comb begin
      w_live = '0;
      for (int unsigned k = 0; k < T; k++)
         w_live[k] = r_slot_v[k] & r_slot_we[k] & (r_slot_rd[k] != '0);
   end

`ifdef PIPE_FORWARD_EN
   // load-use check against stage 2 only; forward select picks the youngest match
   always_comb begin
      w_raw     = w_live[0] & r_slot_ld[0] &
                  ((i_id_rs1_used & (i_id_rs1 == r_slot_rd[0])) |
                   (i_id_rs2_used & (i_id_rs2 == r_slot_rd[0])));
      o_fwd_rs1 = '0;
      o_fwd_rs2 = '0;
      // oldest to youngest so the youngest match overwrites the rest
      for (int unsigned n = T; n > 0; n--) begin
         if (w_live[n-1] && i_id_rs1_used && (i_id_rs1 == r_slot_rd[n-1]))
            o_fwd_rs1 = STG_W'(n + 1);
         if (w_live[n-1] && i_id_rs2_used && (i_id_rs2 == r_slot_rd[n-1]))
            o_fwd_rs2 = STG_W'(n + 1);
      end
   end
`else
   // is_load only matters to the load-use check of the forwarding build
   logic w_unused_ld;
   assign w_unused_ld = ^r_slot_ld;

   // full RAW/WAW interlock against every tracked slot
   always_comb begin
      w_raw = 1'b0;
      for (int unsigned k = 0; k < T; k++) begin
         if (w_live[k] &&
             ((i_id_rs1_used && (i_id_rs1 == r_slot_rd[k])) ||
              (i_id_rs2_used && (i_id_rs2 == r_slot_rd[k])) ||
              (i_id_rd_we    && (i_id_rd  == r_slot_rd[k]))))
            w_raw = 1'b1;
      end
   end
`endif

   // a flush that kills ID makes its interlock moot
   assign w_hazard = i_id_valid & w_raw & ~(w_flush_ok & (w_src > 32'd1));
   assign o_hazard = w_hazard;

   // stall propagates from any requesting stage down to IF; bubble at the stall boundary
   always_comb begin
      o_stall   = '0;
      o_flush   = '0;
      o_bubble  = '0;
      w_req_acc = 1'b0;
      for (int unsigned n = NUM_STAGES; n > 0; n--) begin
         w_req_acc    = w_req_acc | i_stall_req[n-1];
         o_stall[n-1] = w_req_acc | (w_hazard & ((n - 1) <= 1));
      end
      for (int unsigned i = 1; i < NUM_STAGES; i++)
         o_bubble[i] = o_stall[i-1] & ~o_stall[i];
      for (int unsigned i = 0; i < NUM_STAGES; i++)
         o_flush[i] = w_flush_ok & (i < w_src);
   end

   // what each slot would load when its stage advances
   always_comb begin
      w_in_v     = '0;
      w_in_we    = '0;
      w_in_ld    = '0;
      w_in_rd    = '{default: '0};
      w_in_v[0]  = i_id_valid;
      w_in_rd[0] = i_id_rd;
      w_in_we[0] = i_id_rd_we;
      w_in_ld[0] = i_id_is_load;
      for (int unsigned k = 1; k < T; k++) begin
         w_in_v[k]  = r_slot_v[k-1];
         w_in_rd[k] = r_slot_rd[k-1];
         w_in_we[k] = r_slot_we[k-1];
         w_in_ld[k] = r_slot_ld[k-1];
      end
   end

   // slot tracking: hold on stall, take a bubble or flushed producer as invalid
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_slot_v  <= '0;
         r_slot_we <= '0;
         r_slot_ld <= '0;
         for (int unsigned k = 0; k < T; k++)
            r_slot_rd[k] <= '0;
      end else begin
         for (int unsigned k = 0; k < T; k++) begin
            if (!o_stall[k+2]) begin
               r_slot_v[k]  <= w_in_v[k] & ~o_bubble[k+2] & ~o_flush[k+1];
               r_slot_rd[k] <= w_in_rd[k];
               r_slot_we[k] <= w_in_we[k];
               r_slot_ld[k] <= w_in_ld[k];
            end
            // a flush kills the slot even while its stage is held
            if (w_flush_ok && ((k + 2) < w_src))
               r_slot_v[k] <= 1'b0;
         end
      end
   end

   // redirect handshake: a new flush beats a same-cycle ack
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_redirect_valid <= 1'b0;
         r_redirect_addr  <= '0;
      end else if (w_flush_ok) begin
         r_redirect_valid <= 1'b1;
         r_redirect_addr  <= i_flush_addr;
      end else if (i_redirect_ack) begin
         r_redirect_valid <= 1'b0;
      end
   end

   assign o_redirect_valid = r_redirect_valid;
   assign o_redirect_addr  = r_redirect_addr;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table for the interlock, stall,
// flush and redirect sequences, async reset check, then randomized stimulus
// compared against a stage-occupancy reference model.
module tb_pipe_hazard_ctrl;

   localparam int NS = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NS-1:0] stall_req;
   logic          id_valid;
   logic [4:0]    id_rs1, id_rs2, id_rd;
   logic          u1, u2, we, ld;
   logic          fr;
   logic [2:0]    fs;
   logic [31:0]   fa;
   logic          ack;
   logic [NS-1:0] o_stall, o_flush, o_bubble;
   logic          o_hazard, o_rv;
   logic [31:0]   o_ra;
`ifdef PIPE_FORWARD_EN
   logic [2:0]    o_f1, o_f2;
`endif

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.NUM_STAGES(NS), .STG_W(3), .REG_ADDR_W(5), .ADDR_W(32)) dut (
      .i_clk(clk), .i_reset(rst_n), .i_stall_req(stall_req),
      .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
      .i_id_rs1_used(u1), .i_id_rs2_used(u2), .i_id_rd(id_rd),
      .i_id_rd_we(we), .i_id_is_load(ld),
      .i_flush_req(fr), .i_flush_src(fs), .i_flush_addr(fa),
      .i_redirect_ack(ack),
      .o_stall(o_stall), .o_flush(o_flush), .o_bubble(o_bubble),
      .o_hazard(o_hazard), .o_redirect_valid(o_rv), .o_redirect_addr(o_ra)
`ifdef PIPE_FORWARD_EN
      , .o_fwd_rs1(o_f1), .o_fwd_rs2(o_f2)
`endif
   );

   int npass = 0;
   int ntotal = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntotal++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic drive(input logic [4:0] sr, input logic iv, input logic [4:0] r1, input logic a1,
                        input logic [4:0] r2, input logic a2, input logic [4:0] rd, input logic w,
                        input logic l, input logic f, input logic [2:0] s, input logic [31:0] a,
                        input logic k);
      stall_req = sr; id_valid = iv; id_rs1 = r1; u1 = a1; id_rs2 = r2; u2 = a2;
      id_rd = rd; we = w; ld = l; fr = f; fs = s; fa = a; ack = k;
   endtask

   task automatic rand_inputs();
      stall_req = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h00;
      id_valid  = ($urandom_range(0, 3) != 0);
      id_rs1    = 5'($urandom_range(0, 7));
      id_rs2    = 5'($urandom_range(0, 7));
      id_rd     = 5'($urandom_range(0, 7));
      u1        = 1'($urandom);
      u2        = 1'($urandom);
      we        = 1'($urandom);
      ld        = 1'($urandom);
      fr        = ($urandom_range(0, 7) == 0);
      fs        = 3'($urandom_range(0, 7));
      fa        = $urandom;
      ack       = ($urandom_range(0, 2) == 0);
   endtask

   // directed vectors: inputs applied for one cycle, expectations sampled before the edge
   typedef struct {
      logic [4:0] sr; logic iv; logic [4:0] rs1; logic u1; logic [4:0] rd; logic we;
      logic fr; logic [2:0] fs; logic [31:0] fa; logic ack;
      logic [4:0] es, ef, eb; logic eh, erv; logic [31:0] era;
   } vec_t;

   vec_t tbl [40];
   int   nv = 0;

   task automatic add(input logic [4:0] sr, input logic iv, input logic [4:0] rs1, input logic a1,
                      input logic [4:0] rd, input logic w, input logic f, input logic [2:0] s,
                      input logic [31:0] a, input logic k, input logic [4:0] es, input logic [4:0] ef,
                      input logic [4:0] eb, input logic eh, input logic erv, input logic [31:0] era);
      tbl[nv] = '{sr:sr, iv:iv, rs1:rs1, u1:a1, rd:rd, we:w, fr:f, fs:s, fa:a, ack:k,
                  es:es, ef:ef, eb:eb, eh:eh, erv:erv, era:era};
      nv++;
   endtask

   // reference model: instruction occupancy per stage (index = stage number)
   typedef struct packed { logic v; logic [4:0] rd; logic we; logic ld; } ins_t;
   ins_t        mp [NS];
   ins_t        nx [NS];
   ins_t        idi;
   logic        mrv;
   logic [31:0] mra;
   logic        fok, hit, eh;
   int          top;
   logic [NS-1:0] es, ef, eb;
   logic [2:0]  f1, f2;

   function automatic logic live(input ins_t x);
      return x.v && x.we && (x.rd != 5'd0);
   endfunction

   task automatic model_reset();
      for (int s = 0; s < NS; s++) mp[s] = '0;
      mrv = 1'b0;
      mra = '0;
   endtask

`ifdef PIPE_FORWARD_EN
   task automatic fstep(input logic iv, input logic [4:0] r1, input logic a1, input logic [4:0] rd,
                        input logic w, input logic l, input logic exp_h, input logic [2:0] exp_f,
                        input string name);
      @(negedge clk);
      drive(5'h00, iv, r1, a1, 5'd0, 1'b0, rd, w, l, 1'b0, 3'd0, 32'h0, 1'b0);
      #1;
      chk({name, "_hazard"}, 32'(o_hazard), 32'(exp_h));
      chk({name, "_fwd1"}, 32'(o_f1), 32'(exp_f));
   endtask
`endif

   initial begin
      // reset held with random inputs
      rst_n = 1'b0;
      rand_inputs();
      repeat (3) begin
         @(negedge clk);
         rand_inputs();
      end
      #1;
      chk("rst_rv", 32'(o_rv), 32'd0);
      chk("rst_ra", o_ra, 32'd0);
      @(negedge clk);
      drive(5'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 32'h0, 0);
      rst_n = 1'b1;
      #1;
      chk("rel_stall", 32'(o_stall), 32'd0);
      chk("rel_flush", 32'(o_flush), 32'd0);
      chk("rel_bubble", 32'(o_bubble), 32'd0);
      chk("rel_hazard", 32'(o_hazard), 32'd0);
      chk("rel_rv", 32'(o_rv), 32'd0);
      chk("rel_ra", o_ra, 32'd0);

`ifndef PIPE_FORWARD_EN
      //  sr    iv rs1 u1 rd we fr fs fa        ack  es    ef    eb   eh rv ra
      add(5'h00,1, 0, 0, 5, 1, 0, 0, 32'h0,   0, 5'h00,5'h00,5'h00,0,0,32'h0);
      add(5'h00,1, 5, 1, 6, 1, 0, 0, 32'h0,   0, 5'h03,5'h00,5'h04,1,0,32'h0);
      add(5'h00,1, 5, 1, 6, 1, 0, 0, 32'h0,   0, 5'h03,5'h00,5'h04,1,0,32'h0);
      add(5'h00,1, 5, 1, 6, 1, 0, 0, 32'h0,   0, 5'h03,5'h00,5'h04,1,0,32'h0);
      add(5'h00,1, 5, 1, 6, 1, 0, 0, 32'h0,   0, 5'h00,5'h00,5'h00,0,0,32'h0);
      add(5'h00,1, 0, 0, 0, 1, 0, 0, 32'h0,   0, 5'h00,5'h00,5'h00,0,0,32'h0);
      add(5'h00,1, 0, 1, 0, 0, 0, 0, 32'h0,   0, 5'h00,5'h00,5'h00,0,0,32'h0);
      add(5'h00,0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 5'h00,5'h00,5'h00,0,0,32'h0);
      add(5'h00,1, 0, 0, 9, 1, 0, 0, 32'h0,   0, 5'h00,5'h00,5'h00,0,0,32'h0);
      add(5'h00,1, 0, 0,10, 1, 0, 0, 32'h0,   0, 5'h00,5'h00,5'h00,0,0,32'h0);
      for (int i = 0; i < 4; i++)
         add(5'h08,1, 0, 0,11, 1, 0, 0, 32'h0, 0, 5'h0F,5'h00,5'h10,0,0,32'h0);
      add(5'h00,1,10, 1, 0, 0, 0, 0, 32'h0,   0, 5'h03,5'h00,5'h04,1,0,32'h0);
      add(5'h00,1, 9, 1, 0, 0, 0, 0, 32'h0,   0, 5'h03,5'h00,5'h04,1,0,32'h0);
      add(5'h00,1,10, 1, 0, 0, 1, 2, 32'h80,  0, 5'h00,5'h03,5'h00,0,0,32'h0);
      add(5'h00,0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 5'h00,5'h00,5'h00,0,1,32'h80);
      add(5'h00,0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 5'h00,5'h00,5'h00,0,1,32'h80);
      add(5'h00,0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 5'h00,5'h00,5'h00,0,0,32'h80);
      add(5'h00,0, 0, 0, 0, 0, 1, 3, 32'h100, 0, 5'h00,5'h07,5'h00,0,0,32'h80);
      add(5'h00,0, 0, 0, 0, 0, 1, 4, 32'h200, 1, 5'h00,5'h0F,5'h00,0,1,32'h100);
      add(5'h00,0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 5'h00,5'h00,5'h00,0,1,32'h200);
      add(5'h00,0, 0, 0, 0, 0, 1, 0, 32'h300, 0, 5'h00,5'h00,5'h00,0,1,32'h200);
      add(5'h00,0, 0, 0, 0, 0, 1, 5, 32'h400, 1, 5'h00,5'h00,5'h00,0,1,32'h200);
      add(5'h00,0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 5'h00,5'h00,5'h00,0,0,32'h200);
      add(5'h00,1, 0, 0,12, 1, 0, 0, 32'h0,   0, 5'h00,5'h00,5'h00,0,0,32'h200);
      add(5'h00,1, 0, 0,13, 1, 0, 0, 32'h0,   0, 5'h00,5'h00,5'h00,0,0,32'h200);
      add(5'h08,0, 0, 0, 0, 0, 1, 4, 32'h44,  0, 5'h0F,5'h0F,5'h10,0,0,32'h200);
      add(5'h00,1,12, 1,13, 1, 0, 0, 32'h0,   0, 5'h00,5'h00,5'h00,0,1,32'h44);
      add(5'h00,0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 5'h00,5'h00,5'h00,0,1,32'h44);
      add(5'h00,0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 5'h00,5'h00,5'h00,0,0,32'h44);

      for (int n = 0; n < nv; n++) begin
         @(negedge clk);
         drive(tbl[n].sr, tbl[n].iv, tbl[n].rs1, tbl[n].u1, 5'd0, 1'b0, tbl[n].rd, tbl[n].we,
               1'b0, tbl[n].fr, tbl[n].fs, tbl[n].fa, tbl[n].ack);
         #1;
         chk($sformatf("vec%0d_stall", n), 32'(o_stall), 32'(tbl[n].es));
         chk($sformatf("vec%0d_flush", n), 32'(o_flush), 32'(tbl[n].ef));
         chk($sformatf("vec%0d_bubble", n), 32'(o_bubble), 32'(tbl[n].eb));
         chk($sformatf("vec%0d_hazard", n), 32'(o_hazard), 32'(tbl[n].eh));
         chk($sformatf("vec%0d_rv", n), 32'(o_rv), 32'(tbl[n].erv));
         chk($sformatf("vec%0d_ra", n), o_ra, tbl[n].era);
      end
`else
      fstep(1, 5'd0, 0, 5'd7, 1, 0, 0, 3'd0, "alu_issue");
      fstep(1, 5'd7, 1, 5'd0, 0, 0, 0, 3'd2, "alu_use");
      repeat (3) fstep(0, 5'd0, 0, 5'd0, 0, 0, 0, 3'd0, "drain");
      fstep(1, 5'd0, 0, 5'd7, 1, 1, 0, 3'd0, "ld_issue");
      fstep(1, 5'd7, 1, 5'd0, 0, 0, 1, 3'd2, "ld_use_stall");
      fstep(1, 5'd7, 1, 5'd0, 0, 0, 0, 3'd3, "ld_use_fwd");
`endif

      // reset asserted mid-operation acts without a clock edge
      @(negedge clk);
      drive(5'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd2, 32'hABC, 0);
      @(negedge clk);
      drive(5'h02, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 32'h0, 0);
      #1;
      chk("pend_rv", 32'(o_rv), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rv", 32'(o_rv), 32'd0);
      chk("async_ra", o_ra, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // randomized run against the reference model
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         rand_inputs();
         #1;
         fok = fr && (fs != 3'd0) && (int'(fs) < NS);
         hit = 1'b0;
`ifdef PIPE_FORWARD_EN
         if (live(mp[2]) && mp[2].ld &&
             ((u1 && id_rs1 == mp[2].rd) || (u2 && id_rs2 == mp[2].rd)))
            hit = 1'b1;
`else
         for (int s = 2; s < NS; s++)
            if (live(mp[s]) && ((u1 && id_rs1 == mp[s].rd) || (u2 && id_rs2 == mp[s].rd) ||
                                (we && id_rd == mp[s].rd)))
               hit = 1'b1;
`endif
         eh  = id_valid && hit && !(fok && fs > 3'd1);
         top = -1;
         for (int j = 0; j < NS; j++) if (stall_req[j]) top = j;
         if (eh && top < 1) top = 1;
         es = '0; eb = '0; ef = '0;
         for (int i = 0; i < NS; i++) begin
            if (i <= top) es[i] = 1'b1;
            if (fok && i < int'(fs)) ef[i] = 1'b1;
         end
         if (top >= 0 && top + 1 < NS) eb[top+1] = 1'b1;
         f1 = 3'd0; f2 = 3'd0;
         for (int s = NS - 1; s >= 2; s--) begin
            if (live(mp[s]) && u1 && id_rs1 == mp[s].rd) f1 = 3'(s);
            if (live(mp[s]) && u2 && id_rs2 == mp[s].rd) f2 = 3'(s);
         end
         chk($sformatf("rnd%0d_stall", c), 32'(o_stall), 32'(es));
         chk($sformatf("rnd%0d_flush", c), 32'(o_flush), 32'(ef));
         chk($sformatf("rnd%0d_bubble", c), 32'(o_bubble), 32'(eb));
         chk($sformatf("rnd%0d_hazard", c), 32'(o_hazard), 32'(eh));
         chk($sformatf("rnd%0d_rv", c), 32'(o_rv), 32'(mrv));
         chk($sformatf("rnd%0d_ra", c), o_ra, mra);
`ifdef PIPE_FORWARD_EN
         chk($sformatf("rnd%0d_fwd1", c), 32'(o_f1), 32'(f1));
         chk($sformatf("rnd%0d_fwd2", c), 32'(o_f2), 32'(f2));
`endif
         // advance the model: flush kills, held stages stay, the rest shift by one
         idi = {id_valid, id_rd, we, ld};
         if (fok) begin
            if (fs > 3'd1) idi.v = 1'b0;
            for (int s = 2; s < NS; s++) if (s < int'(fs)) mp[s].v = 1'b0;
         end
         for (int s = 2; s < NS; s++) begin
            if (s <= top)          nx[s] = mp[s];
            else if (s == top + 1) nx[s] = '0;
            else if (s == 2)       nx[s] = idi;
            else                   nx[s] = mp[s-1];
         end
         for (int s = 2; s < NS; s++) mp[s] = nx[s];
         if (fok) begin
            mrv = 1'b1;
            mra = fa;
         end else if (ack) begin
            mrv = 1'b0;
         end
      end

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline control unit for the in-order core; the successor to the fixed shared-stall wiring.
- Generates per-stage stall, flush and bubble controls for an N-stage pipeline.
- Performs RAW/WAW interlock by tracking destination registers of in-flight instructions.
- Owns the fetch-redirect handshake after a flush.
- Sits beside the stage modules; all stages read its outputs combinationally.

Parameters:
NUM_STAGES, 5, pipeline depth; stage 0 = IF, stage 1 = ID, stage NUM_STAGES-1 = WB; min 3
STG_W, 3, width of stage-index fields; must satisfy 2^STG_W >= NUM_STAGES
REG_ADDR_W, 5, register address width
ADDR_W, 32, redirect address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
stall_req  in  NUM_STAGES  per-stage stall request (e.g. MEM awaiting dmem_ready)
id_valid  in  1  valid instruction in ID
id_rs1  in  REG_ADDR_W  ID source 1
id_rs2  in  REG_ADDR_W  ID source 2
id_rs1_used  in  1  rs1 is read
id_rs2_used  in  1  rs2 is read
id_rd  in  REG_ADDR_W  ID destination
id_rd_we  in  1  ID writes rd
id_is_load  in  1  ID instruction is a load
flush_req  in  1  flush request
flush_src  in  STG_W  stage issuing the flush
flush_addr  in  ADDR_W  redirect target
redirect_ack  in  1  fetch accepted the redirect
stall  out  NUM_STAGES  per-stage hold
flush  out  NUM_STAGES  per-stage invalidate
bubble  out  NUM_STAGES  insert NOP into this stage's input register
hazard  out  1  ID interlock active
redirect_valid  out  1  redirect pending
redirect_addr  out  ADDR_W  redirect target

Behaviour:
- Reset (async, reset low): all tracked slots invalid; redirect_valid=0; redirect_addr=0. With stall_req=0 and flush_req=0, stall, flush, bubble and hazard are all 0.
- Tracked slots T = NUM_STAGES-2, one per stage 2..NUM_STAGES-1. Each slot holds {valid, rd, we, is_load}. A slot is a match when valid & we & rd!=0.
- Hazard (combinational): id_valid & ((id_rs1_used & rs1 matches a slot) | (id_rs2_used & rs2 matches a slot) | (id_rd_we & rd matches a slot)). Register x0 never causes a hazard.
- Stall (combinational):
  - stall[i] = OR(stall_req[j], j>=i) | (hazard & i<=1).
  - An older stall always holds every younger stage.
- Bubble: bubble[i] = stall[i-1] & ~stall[i] for i>=1; bubble[0]=0.
- Slot update per clock, slot k at stage s=k+2:
  - If stall[s], hold.
  - Else if stage s-1 bubbled or flushed, load invalid.
  - Else load the slot for stage s-1. Slot 0 loads {id_valid, id_rd, id_rd_we, id_is_load}.
  - The WB slot is overwritten, which retires it.
- Flush:
  - flush_req pulses flush[i]=1 for all i < flush_src for one cycle (combinational).
  - Slots whose stage < flush_src are invalidated on the next edge.
  - Flush overrides hazard: hazard is forced 0 when flush_src > 1.
  - flush_src=0 or flush_src>=NUM_STAGES is ignored entirely: no flush, no redirect.
- Redirect:
  - On an accepted flush, redirect_valid<=1 and redirect_addr<=flush_addr next cycle.
  - The redirect holds until redirect_ack is sampled high, then redirect_valid<=0.
  - A new flush_req while pending overwrites redirect_addr and keeps redirect_valid=1.
  - Same-cycle ack and new flush: the flush wins, so redirect_valid stays 1 with the new address.
- Simultaneous stall_req and flush_req: both apply. Flushed stages are invalidated even if held.
- Reset mid-operation clears all state immediately; outputs return to their reset values asynchronously.

Optional Feature:
- Macro PIPE_FORWARD_EN.
- When defined:
  - Hazard considers only slot 0 with is_load=1 (load-use). All other RAW cases are resolved by forwarding.
  - Adds outputs fwd_rs1 and fwd_rs2, each STG_W wide. Each gives the youngest matching slot's stage index, or 0 for no forward.
  - WAW never stalls.
- When undefined: full interlock as above; no forwarding ports.

Test Plan:
- Reset: hold reset=0 with random inputs, then release -> all outputs 0; redirect_addr=0.
- RAW interlock:
  - Issue rd=5 (we=1), then ID reads rs1=5 -> hazard=1, stall=5'b00011, bubble[2]=1.
  - Stall persists 3 cycles until the slot retires past WB, then hazard=0.
  - Repeat with rd=0 -> no stall.
- Memory stall: stall_req[3]=1 for 4 cycles -> stall=5'b01111, bubble[4]=1 each cycle; slot contents for stages 2–3 unchanged.
- Flush from EX:
  - flush_req=1, flush_src=2, flush_addr=0x80 -> flush=5'b00011 for one cycle; hazard on stage-1 data cleared.
  - Next cycle redirect_valid=1, redirect_addr=0x80.
  - ack after 2 cycles -> redirect_valid=0.
- Re-flush while pending: flush to 0x100, then flush to 0x200 the same cycle as redirect_ack -> redirect_valid stays 1, redirect_addr=0x200.
- PIPE_FORWARD_EN:
  - ALU rd=7 followed by a reader of 7 -> no hazard, fwd_rs1=2.
  - Load rd=7 followed by a reader -> exactly one stall cycle, then fwd_rs1=3.
